// File: rtl/derect_pkg.sv
// Shared defaults, signed-range helpers and the sign-restore conversion
// used by the derectifier receive path.
package derect_pkg;

  localparam int N_DEF     = 16;
  localparam int DEPTH_DEF = 4;
  localparam int CW_DEF    = 16;

  // Conversion is computed at this fixed width and truncated by the caller,
  // so one function serves every sample width up to MAXW.
  localparam int MAXW = 64;

  typedef struct packed {
    logic            is_neg;
    logic            is_sat;
    logic [MAXW-1:0] value;
  } restore_t;

  // Largest positive n-bit two's-complement value, zero-extended.
  function automatic logic [MAXW-1:0] maxp(input int n);
    return (MAXW'(1) << (n - 1)) - MAXW'(1);
  endfunction

  // Most negative n-bit value, sign-extended to MAXW bits.
  function automatic logic [MAXW-1:0] minn(input int n);
    return ~maxp(n);
  endfunction

  // {sign, magnitude} -> signed value; magnitudes beyond the signed range
  // clamp to the nearest limit and flag saturation. A negative zero maps to
  // 0 and is not reported as negative.
  function automatic restore_t sign_restore(input logic sign,
                                            input logic [MAXW-1:0] mag,
                                            input int n);
    restore_t r;
    logic [MAXW-1:0] half;
    half     = maxp(n) + MAXW'(1);
    r.is_neg = 1'b0;
    r.is_sat = 1'b0;
    r.value  = '0;
    if (!sign) begin
      if (mag > maxp(n)) begin
        r.value  = maxp(n);
        r.is_sat = 1'b1;
      end else begin
        r.value  = mag;
      end
    end else if (mag != '0) begin
      r.is_neg = 1'b1;
      if (mag > half) begin
        r.value  = minn(n);
        r.is_sat = 1'b1;
      end else begin
        r.value  = '0 - mag;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/derect_fifo.sv
// Small synchronous FIFO: power-of-two depth, pointers wrap naturally,
// occupancy kept in a separate counter so full and empty are unambiguous.
module derect_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty,
  output logic [AW:0]  o_occ
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_occ   = r_cnt;
  assign o_rdata = r_mem[r_rd_ptr];

  // Storage needs no reset: pointers/occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/derectifier.sv
// Receive side of the rectified stream: buffers {sign, magnitude} samples,
// restores the signed value on the output register load and keeps
// negative/saturation statistics.
module derectifier
  import derect_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CW_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  input  logic          in_sign,
  output logic          in_ready,
  output logic          stop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  input  logic          clr_stats,
  output logic [CW-1:0] neg_count,
  output logic [CW-1:0] sat_count,
  output logic          sat_flag
);

  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_occ;
  logic          w_push;
  logic          w_pop;
  logic [N:0]    w_rd;
  restore_t      w_res;
  logic [N-1:0]  w_val;

  logic          r_out_valid;
  logic [N-1:0]  r_out_data;
  logic [CW-1:0] r_neg_cnt;
  logic [CW-1:0] r_sat_cnt;
  logic          r_sat_flag;

  assign in_ready = (w_occ < (AW+1)'(DEPTH));
  assign stop     = ~in_ready;
  assign w_push   = in_valid && !w_full;
  // Output register refills whenever it is empty or being drained.
  assign w_pop    = !w_empty && (!r_out_valid || out_ready);

  derect_fifo #(.W(N+1), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({in_sign, in_data}),
    .i_pop   (w_pop),
    .o_rdata (w_rd),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_occ   (w_occ)
  );

  assign w_res = sign_restore(w_rd[N], MAXW'(w_rd[N-1:0]), N);
  assign w_val = w_res.value[N-1:0];

  // Upper bits of the wide conversion result are sign/zero extension only.
  generate
    if (N < MAXW) begin : g_ext
      logic w_unused;
      assign w_unused = ^w_res.value[MAXW-1:N];
    end
  endgenerate

  // Output register: load on pop, drop valid when drained with nothing queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_val;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Statistics follow loads; a clear in the same cycle discards that event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_cnt  <= '0;
      r_sat_cnt  <= '0;
      r_sat_flag <= 1'b0;
    end else if (clr_stats) begin
      r_neg_cnt  <= '0;
      r_sat_cnt  <= '0;
      r_sat_flag <= 1'b0;
    end else if (w_pop) begin
      if (w_res.is_neg) r_neg_cnt <= r_neg_cnt + CW'(1);
      if (w_res.is_sat) begin
        r_sat_cnt  <= r_sat_cnt + CW'(1);
        r_sat_flag <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign neg_count = r_neg_cnt;
  assign sat_count = r_sat_cnt;
  assign sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_derectifier.sv
// Directed bench for derectifier: a queue-level reference model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_derectifier;

  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          in_sign = 1'b0;
  logic          in_ready;
  logic          stop;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  out_data;
  logic          clr_stats = 1'b0;
  logic [CW-1:0] neg_count;
  logic [CW-1:0] sat_count;
  logic          sat_flag;

  int nchecks = 0;
  int nerr    = 0;
  int hs      = 0;
  int hs0;

  derectifier #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sign   (in_sign),
    .in_ready  (in_ready),
    .stop      (stop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .clr_stats (clr_stats),
    .neg_count (neg_count),
    .sat_count (sat_count),
    .sat_flag  (sat_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Signed reconstruction from the value rules, in plain integer arithmetic.
  function automatic logic [N-1:0] conv(input logic s, input logic [N-1:0] m,
                                        output bit ng, output bit st);
    int v;
    int mi;
    mi = int'(m);
    ng = 0;
    st = 0;
    if (!s) begin
      if (mi > 2**(N-1) - 1) begin v = 2**(N-1) - 1; st = 1; end
      else v = mi;
    end else if (mi == 0) begin
      v = 0;
    end else begin
      ng = 1;
      if (mi > 2**(N-1)) begin v = -(2**(N-1)); st = 1; end
      else v = -mi;
    end
    return v[N-1:0];
  endfunction

  // Reference model state
  logic [N:0]    mq[$];
  bit            mv = 0;
  logic [N-1:0]  md = '0;
  logic [CW-1:0] mneg = '0;
  logic [CW-1:0] msat = '0;
  bit            mflag = 0;

  // Model: advance one cycle per edge, clear everything on reset.
  initial begin
    logic [N:0] e;
    bit ng, st, pu, ld;
    int sz;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        mv = 0; md = '0; mneg = '0; msat = '0; mflag = 0;
      end else begin
        sz = mq.size();
        pu = in_valid && (sz < DEPTH);
        ld = (sz > 0) && (!mv || out_ready);
        ng = 0; st = 0;
        if (ld) begin
          e  = mq.pop_front();
          md = conv(e[N], e[N-1:0], ng, st);
          mv = 1;
        end else if (mv && out_ready) begin
          mv = 0;
        end
        if (clr_stats) begin
          mneg = '0; msat = '0; mflag = 0;
        end else if (ld) begin
          if (ng) mneg = mneg + CW'(1);
          if (st) begin msat = msat + CW'(1); mflag = 1; end
        end
        if (pu) mq.push_back({in_sign, in_data});
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
      check("stop",      32'(stop),      32'(!(mq.size() < DEPTH)));
      check("out_valid", 32'(out_valid), 32'(mv));
      check("out_data",  32'(out_data),  32'(md));
      check("neg_count", 32'(neg_count), 32'(mneg));
      check("sat_count", 32'(sat_count), 32'(msat));
      check("sat_flag",  32'(sat_flag),  32'(mflag));
      if (out_valid && out_ready) hs++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the sample until an edge where in_ready was high.
  task automatic push(input logic s, input logic [N-1:0] m);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1; in_sign = s; in_data = m;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      nchecks++; nerr++;
      $display("FAIL push_timeout: got no acceptance expected accept within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);
    check("rst_stop",      32'(stop),      32'h0);
    check("rst_counts",    32'({neg_count, sat_count}), 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Single negative sample, one-cycle latency
    push(1'b1, 16'h0005);
    idle(1);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_data",  32'(out_data),  32'hFFFB);
    check("t1_neg",   32'(neg_count), 32'h1);

    // Saturation boundaries
    clr_stats = 1'b1; idle(1); clr_stats = 1'b0;
    push(1'b0, 16'h9000);
    push(1'b1, 16'h8000);
    push(1'b1, 16'h8001);
    idle(3);
    check("t2_data", 32'(out_data),  32'h8000);
    check("t2_sat",  32'(sat_count), 32'h2);
    check("t2_flag", 32'(sat_flag),  32'h1);
    check("t2_neg",  32'(neg_count), 32'h2);

    // Back-pressure: 1 in output register + 4 in FIFO
    hs0 = hs;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(i[0], 16'h0100 + 16'(i));
    @(negedge clk);
    check("t3_in_ready", 32'(in_ready), 32'h0);
    check("t3_stop",     32'(stop),     32'h1);
    check("t3_hold",     32'(out_data), 32'h0100);
    idle(2);
    check("t3_hold2",    32'(out_data), 32'h0100);
    out_ready = 1'b1;
    push(1'b1, 16'h0105);
    idle(8);
    check("t3_emitted",  32'(hs - hs0), 32'd6);
    check("t3_neg",      32'(neg_count), 32'h5);

    // Negative zero
    push(1'b1, 16'h0000);
    idle(1);
    check("t4_data",  32'(out_data),  32'h0);
    check("t4_valid", 32'(out_valid), 32'h1);
    check("t4_neg",   32'(neg_count), 32'h5);

    // Reset mid-burst with 3 entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 16'h0010 + 16'(i));
    rst_n = 1'b0;
    #2;
    check("t5_valid",    32'(out_valid), 32'h0);
    check("t5_counts",   32'({neg_count, sat_count}), 32'h0);
    check("t5_flag",     32'(sat_flag),  32'h0);
    check("t5_in_ready", 32'(in_ready),  32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    hs0 = hs;
    idle(5);
    check("t5_no_stale", 32'(hs - hs0), 32'd0);
    check("t5_valid2",   32'(out_valid), 32'h0);

    // Clear coincident with a saturating load
    push(1'b1, 16'h9000);
    idle(2);
    check("t6_pre_flag", 32'(sat_flag),  32'h1);
    check("t6_pre_data", 32'(out_data),  32'h8000);
    push(1'b0, 16'hFFFF);
    clr_stats = 1'b1; idle(1); clr_stats = 1'b0;
    check("t6_sat",   32'(sat_count), 32'h0);
    check("t6_flag",  32'(sat_flag),  32'h0);
    check("t6_neg",   32'(neg_count), 32'h0);
    check("t6_data",  32'(out_data),  32'h7FFF);
    check("t6_valid", 32'(out_valid), 32'h1);

    idle(3);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
